uflash_ctrl_sim: RTL
====================

# uflash_ctrl_sim

Cycle-level, synthesizable stand-in for the Gowin user-flash controller, i.e. the responder side of the start_flag/done_flag handshake that the uflash bus bridge drives. It holds a word-addressed flash array with real flash semantics: erased = all ones, and program can only clear bits. Each operation has a parameterised busy time, so the bridge and CPU firmware can be simulated, and run on parts without user flash, without the encrypted IP.

## Interface

Parameters:
- ROWS, 304: number of 64-word rows; the array is ROWS*64 32-bit words.
- PAGE_ROWS, 8: rows per erase page (8 rows = 512 words = 2048 bytes).
- RD_CYCLES, 6: read latency in clk cycles, ≥2.
- WR_CYCLES, 40: program latency in clk cycles, ≥2.
- ER_CYCLES, 600: erase latency in clk cycles, ≥ PAGE_ROWS*64 + 2.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- start_flag_i  in  1  one-cycle request pulse
- wr_en_i  in  1  program request (sampled with start)
- erase_en_i  in  1  page-erase request (sampled with start)
- wxaddr_i  in  9  row address
- wyaddr_i  in  6  column (word) address
- wdata_i  in  32  program data
- rdata_o  out  32  read data; holds the last read value
- done_flag_o  out  1  one-cycle completion pulse
- busy_o  out  1  operation in progress
- prog_err_o  out  1  sticky: a program tried to turn a 0 bit into a 1

## Operation

- States: IDLE, RD, WR, ER_SWEEP, ER_WAIT, DONE.
- IDLE, start_flag_i=1: latch the address, data and op; load the cycle counter; go to the op state.
  - erase_en_i=1 → erase. Erase wins over wr_en_i.
  - else wr_en_i=1 → program.
  - else → read.
- start_flag_i outside IDLE is ignored. No queueing, no error.
- Read: when the counter expires, register mem[row*64+col] into rdata_o, then go to DONE.
- Program: mem[a] <= mem[a] & wdata. If (~mem[a] & wdata) != 0, set prog_err_o. The write happens when the counter expires, then go to DONE.
- Erase: page base row = (row / PAGE_ROWS) * PAGE_ROWS.
  - ER_SWEEP writes 32'hFFFF_FFFF to one word per cycle across all PAGE_ROWS*64 words, using a sweep counter.
  - ER_WAIT then burns the remaining ER_CYCLES budget.
  - Then go to DONE.
- Out-of-range row (row ≥ ROWS):
  - Read returns 32'hFFFF_FFFF.
  - Program and erase do not touch the array.
  - Timing is unchanged and done_flag_o still pulses.
- DONE: done_flag_o=1 for exactly this cycle, then IDLE.
- prog_err_o clears only on reset.
- Array contents: initialised to all ones at time zero. They are not affected by reset_n.

## Timing

- Reset values: rdata_o=0, done_flag_o=0, busy_o=0, prog_err_o=0, state IDLE, counters 0.
- start_flag_i is sampled high at edge k. Then:
  - busy_o=1 from after edge k until the edge at which done_flag_o falls.
  - done_flag_o is high in cycle k+N, where N = RD_CYCLES, WR_CYCLES or ER_CYCLES depending on the op.
- Read: rdata_o takes the new value at the same edge at which done_flag_o rises, and holds it until the next read completes.
- Program: the array update is visible to any read that starts at or after the done cycle.
- Back-to-back: a new start_flag_i in the done cycle is ignored. The earliest accepted start is at edge k+N+1.
- Reset asserted mid-operation:
  - Immediately abort: IDLE, done low, busy low.
  - A partial erase leaves the words already swept at all ones; the rest are unchanged.
  - A program aborted before counter expiry leaves the array untouched.
- busy_o is combinational from state. All other outputs are registered.

## Test plan

- Read after reset: start a read at row 0, col 0 → done after exactly RD_CYCLES; rdata_o = FFFF_FFFF.
- Program then read, row 3 col 5: program 1234_5678, then read → rdata_o = 1234_5678; prog_err_o = 0.
- Bit-set violation: program 0000_00F0, then program 0000_000F at the same word → read gives 0000_0000; prog_err_o = 1 and stays 1.
- Page erase: program words at rows 8 and 15 (page 1) and at row 16. Erase with address row 12 → row 8 and row 15 words read FFFF_FFFF; the row 16 word keeps its value; done arrives at ER_CYCLES.
- Busy and priority:
  - Pulse start again mid-program → ignored; exactly one done pulse.
  - wr_en=erase_en=1 → erase is performed.
  - Row 400 read → FFFF_FFFF.
- Reset mid-erase: assert reset_n low 100 cycles into the sweep → outputs go to reset values; swept words read FFFF_FFFF; unswept words keep their contents.

Source files
------------

// File: rtl/uflash_ctrl_sim.sv
// uflash_ctrl_sim -- cycle-level model of the user-flash controller (responder
// side of the start_flag/done_flag handshake). Word-addressed flash array with
// flash semantics (erased = all ones, program only clears bits) and
// parameterised busy times for read, program and page erase.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   start_flag_i      one-cycle request pulse, honoured only when idle
//   wr_en_i           program request (sampled with start)
//   erase_en_i        page-erase request (sampled with start, wins over wr_en_i)
//   wxaddr_i          row address (64 words per row)
//   wyaddr_i          column (word) address within the row
//   wdata_i           program data
//   rdata_o           read data, holds the last read value
//   done_flag_o       one-cycle completion pulse
//   busy_o            operation in progress (combinational from state)
//   prog_err_o        sticky: a program tried to turn a 0 bit into a 1
//
// Timing: with start sampled at edge k, the controller is in its op state for
// N-1 cycles, spends one cycle in DONE (done_flag_o high) and is idle again at
// edge k+N, so the earliest accepted follow-up start is at edge k+N+1.
module uflash_ctrl_sim #(
    parameter int ROWS      = 304,
    parameter int PAGE_ROWS = 8,
    parameter int RD_CYCLES = 6,
    parameter int WR_CYCLES = 40,
    parameter int ER_CYCLES = 600
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_flag_i,
    input  logic        wr_en_i,
    input  logic        erase_en_i,
    input  logic [8:0]  wxaddr_i,
    input  logic [5:0]  wyaddr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        done_flag_o,
    output logic        busy_o,
    output logic        prog_err_o
);

    localparam int WORDS      = ROWS * 64;
    localparam int AW         = $clog2(WORDS);
    localparam int PAGE_WORDS = PAGE_ROWS * 64;
    localparam int SW         = $clog2(PAGE_WORDS);

    localparam logic [9:0]    ROWS_L     = 10'(ROWS);
    localparam logic [9:0]    PR_L       = 10'(PAGE_ROWS);
    localparam logic [15:0]   WORDS_L    = 16'(WORDS);
    localparam logic [SW-1:0] LAST_SWEEP = SW'(PAGE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WR, S_ER_SWEEP, S_ER_WAIT, S_DONE
    } state_t;

    state_t         state_reg, state_next;
    logic [8:0]     row_reg;
    logic [5:0]     col_reg;
    logic [31:0]    wdata_reg;
    logic [31:0]    cnt_reg;
    logic [SW-1:0]  sweep_reg;

    // The array is stored inverted so that the all-zero power-up content of
    // block RAM reads back as erased flash (all ones).
    logic [31:0]    mem_n [WORDS];
    logic [31:0]    rd_word_n_reg;

    logic [8:0]     cur_row;
    logic [5:0]     cur_col;
    logic           cur_row_ok;
    logic           row_ok;
    logic [14:0]    rd_lin;
    logic [AW-1:0]  rd_addr;
    logic [9:0]     page_row;
    logic [15:0]    er_lin;
    logic           cnt_zero;

    logic           mem_we;
    logic [AW-1:0]  mem_waddr;
    logic [31:0]    mem_wdata;

    // While idle the RAM is addressed straight from the request inputs, so the
    // word is already registered one cycle after start; this keeps the
    // read-modify-write of a program correct even at the minimum latency of 2.
    assign cur_row    = (state_reg == S_IDLE) ? wxaddr_i : row_reg;
    assign cur_col    = (state_reg == S_IDLE) ? wyaddr_i : col_reg;
    assign cur_row_ok = ({1'b0, cur_row} < ROWS_L);
    assign row_ok     = ({1'b0, row_reg} < ROWS_L);
    assign rd_lin     = {cur_row, cur_col};
    assign rd_addr    = cur_row_ok ? rd_lin[AW-1:0] : '0;
    assign page_row   = ({1'b0, row_reg} / PR_L) * PR_L;
    assign er_lin     = {page_row, 6'b0} + 16'(sweep_reg);
    assign cnt_zero   = (cnt_reg == 32'd0);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start_flag_i) begin
                    if (erase_en_i)   state_next = S_ER_SWEEP;
                    else if (wr_en_i) state_next = S_WR;
                    else              state_next = S_RD;
                end
            end
            S_RD, S_WR: begin
                if (cnt_zero) state_next = S_DONE;
            end
            S_ER_SWEEP: begin
                if (sweep_reg == LAST_SWEEP) state_next = cnt_zero ? S_DONE : S_ER_WAIT;
            end
            S_ER_WAIT: begin
                if (cnt_zero) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output / array-write decode
    always_comb begin
        busy_o    = (state_reg != S_IDLE);
        mem_we    = 1'b0;
        mem_waddr = rd_addr;
        mem_wdata = rd_word_n_reg | ~wdata_reg;   // inverted form of old & wdata
        case (state_reg)
            S_WR: begin
                mem_we = cnt_zero && row_ok;
            end
            S_ER_SWEEP: begin
                // The final page may overhang the array; skip those words.
                mem_we    = row_ok && (er_lin < WORDS_L);
                mem_waddr = er_lin[AW-1:0];
                mem_wdata = 32'h0000_0000;        // inverted all-ones
            end
            default: ;
        endcase
    end

    // Flash array: contents survive reset_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_n[mem_waddr] <= mem_wdata;
        end
        rd_word_n_reg <= mem_n[rd_addr];
    end

    // Request latch, counters and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_reg     <= '0;
            col_reg     <= '0;
            wdata_reg   <= '0;
            cnt_reg     <= '0;
            sweep_reg   <= '0;
            rdata_o     <= '0;
            done_flag_o <= 1'b0;
            prog_err_o  <= 1'b0;
        end else begin
            done_flag_o <= (state_next == S_DONE);
            if (state_reg == S_IDLE) begin
                if (start_flag_i) begin
                    row_reg   <= wxaddr_i;
                    col_reg   <= wyaddr_i;
                    wdata_reg <= wdata_i;
                    sweep_reg <= '0;
                    // Loaded with N-2: N-1 op cycles, the last one at zero.
                    if (erase_en_i)   cnt_reg <= 32'(ER_CYCLES - 2);
                    else if (wr_en_i) cnt_reg <= 32'(WR_CYCLES - 2);
                    else              cnt_reg <= 32'(RD_CYCLES - 2);
                end
            end else if (state_reg != S_DONE) begin
                if (!cnt_zero) cnt_reg <= cnt_reg - 32'd1;
                if (state_reg == S_ER_SWEEP) sweep_reg <= sweep_reg + 1'b1;
                if (state_reg == S_RD && cnt_zero) begin
                    rdata_o <= row_ok ? ~rd_word_n_reg : 32'hFFFF_FFFF;
                end
                // A set bit in wdata over a stored 0 cannot be programmed.
                if (state_reg == S_WR && cnt_zero && row_ok &&
                    ((rd_word_n_reg & wdata_reg) != 32'd0)) begin
                    prog_err_o <= 1'b1;
                end
            end
        end
    end

endmodule
